// File: rtl/xmem_row_server_if.sv
// -----------------------------------------------------------------------------
// xmem_row_if
// Row-granular read/write request bus between an accelerator client (master)
// and the xmem row server (slave).
//   rd_req / rd_start_addr / rd_size_bytes  : read request, held until rd_valid
//   rd_data / rd_valid                      : read row + one-cycle pulse
//   wr_req / wr_start_addr / wr_size_bytes  : write request, held until wr_ack
//   wr_data / wr_ack                        : write row + one-cycle completion
//   err / err_clr                           : sticky out-of-range flag + clear
// -----------------------------------------------------------------------------
interface xmem_row_if #(
   parameter int ADDR_W         = 16,
   parameter int MAX_XFER_BYTES = 32
);
   localparam int SIZE_W = $clog2(MAX_XFER_BYTES) + 1;

   logic                              rd_req;
   logic [ADDR_W-1:0]                 rd_start_addr;
   logic [SIZE_W-1:0]                 rd_size_bytes;
   logic [MAX_XFER_BYTES-1:0][7:0]    rd_data;
   logic                              rd_valid;

   logic                              wr_req;
   logic [ADDR_W-1:0]                 wr_start_addr;
   logic [SIZE_W-1:0]                 wr_size_bytes;
   logic [MAX_XFER_BYTES-1:0][7:0]    wr_data;
   logic                              wr_ack;

   logic                              err;
   logic                              err_clr;

   modport master (
      output rd_req, rd_start_addr, rd_size_bytes,
      output wr_req, wr_start_addr, wr_size_bytes, wr_data, err_clr,
      input  rd_data, rd_valid, wr_ack, err
   );

   modport slave (
      input  rd_req, rd_start_addr, rd_size_bytes,
      input  wr_req, wr_start_addr, wr_size_bytes, wr_data, err_clr,
      output rd_data, rd_valid, wr_ack, err
   );
endinterface

// File: rtl/xmem_row_server.sv
// -----------------------------------------------------------------------------
// xmem_row_server
// Memory-side responder for row read/write requests. Owns a byte-addressable
// backing store, serves one request at a time, moves BEAT_BYTES per cycle and
// answers with a one-cycle rd_valid (whole row) or wr_ack pulse.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (store contents are kept)
//   bus    : xmem_row_if.slave (requests in, rd_data/rd_valid/wr_ack/err out)
// Optional feature: define XMEM_SRV_BOUNDS_CHECK_EN to reject requests with
// start_addr + size > MEM_BYTES (no access, sticky err). Without it addresses
// wrap modulo MEM_BYTES and err stays 0.
// -----------------------------------------------------------------------------
module xmem_row_server #(
   parameter int MEM_BYTES      = 65536,
   parameter int ADDR_W         = 16,
   parameter int MAX_XFER_BYTES = 32,
   parameter int BEAT_BYTES     = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   xmem_row_if.slave bus
);
   localparam int MEM_AW = $clog2(MEM_BYTES);
   localparam int SIZE_W = $clog2(MAX_XFER_BYTES) + 1;
   localparam int IDX_W  = $clog2(MAX_XFER_BYTES);

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, RESP} state_t;

   state_t                          r_state, w_state_nxt;
   logic [7:0]                      r_mem [MEM_BYTES];
   logic [ADDR_W-1:0]               r_addr;
   logic [SIZE_W-1:0]               r_size, r_off;
   logic [MAX_XFER_BYTES-1:0][7:0]  r_wdata, r_rd_data;
   logic                            r_is_rd, r_last_was_rd, r_oob;
   logic                            r_rd_valid, r_wr_ack, r_err;

   logic                            w_sel_rd, w_acc_rd, w_acc_wr, w_acc;
   logic                            w_last_beat, w_is_rd_nxt, w_oob_nxt, w_req_oob;
   logic                            w_resp_nxt;
   logic [ADDR_W-1:0]               w_req_addr;
   logic [SIZE_W-1:0]               w_req_raw, w_req_size;

   // Both pending: serve the type not served last (reads win after reset).
   assign w_sel_rd   = bus.rd_req && (!bus.wr_req || !r_last_was_rd);
   assign w_acc_rd   = (r_state == IDLE) && w_sel_rd;
   assign w_acc_wr   = (r_state == IDLE) && bus.wr_req && !w_sel_rd;
   assign w_acc      = w_acc_rd || w_acc_wr;
   assign w_req_addr = w_sel_rd ? bus.rd_start_addr : bus.wr_start_addr;
   assign w_req_raw  = w_sel_rd ? bus.rd_size_bytes : bus.wr_size_bytes;
   assign w_req_size = (w_req_raw > SIZE_W'(MAX_XFER_BYTES)) ?
                       SIZE_W'(MAX_XFER_BYTES) : w_req_raw;
   // r_off + BEAT_BYTES stays below 2*MAX_XFER_BYTES, so SIZE_W cannot overflow.
   assign w_last_beat = (r_off + SIZE_W'(BEAT_BYTES)) >= r_size;

`ifdef XMEM_SRV_BOUNDS_CHECK_EN
   assign w_req_oob = ({1'b0, w_req_addr} + (ADDR_W+1)'(w_req_size)) >
                      (ADDR_W+1)'(MEM_BYTES);
`else
   assign w_req_oob = 1'b0;
`endif

   // Registered outputs are computed from the state being entered, so the
   // pulse lands in the RESP cycle itself.
   assign w_is_rd_nxt = (r_state == IDLE) ? w_sel_rd  : r_is_rd;
   assign w_oob_nxt   = (r_state == IDLE) ? w_req_oob : r_oob;
   assign w_resp_nxt  = (w_state_nxt == RESP);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:
            if (w_acc)
               w_state_nxt = (w_req_size == '0) ? RESP :
                             (w_acc_rd ? RD_BURST : WR_BURST);
         RD_BURST, WR_BURST:
            if (w_last_beat) w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------- per-lane beat addressing ----------------
   logic [BEAT_BYTES-1:0]             w_lane_en;
   logic [BEAT_BYTES-1:0][MEM_AW-1:0] w_lane_addr;
   logic [BEAT_BYTES-1:0][IDX_W-1:0]  w_lane_idx;

   for (genvar j = 0; j < BEAT_BYTES; j++) begin : g_lane
      logic [SIZE_W-1:0] w_off;
      assign w_off          = r_off + SIZE_W'(j);
      // Lanes past the row length (or of a rejected request) touch nothing.
      assign w_lane_en[j]   = (w_off < r_size) && !r_oob;
      assign w_lane_idx[j]  = w_off[IDX_W-1:0];
      // MEM_AW-bit add gives the modulo-MEM_BYTES wrap.
      assign w_lane_addr[j] = r_addr[MEM_AW-1:0] + MEM_AW'(w_off);
   end

   // Backing store: never reset; a reset mid-burst leaves a partial row.
   always_ff @(posedge clk) begin
      if (r_state == WR_BURST)
         for (int j = 0; j < BEAT_BYTES; j++)
            if (w_lane_en[j]) r_mem[w_lane_addr[j]] <= r_wdata[w_lane_idx[j]];
   end

   // ---------------- datapath / outputs ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr        <= '0;
         r_size        <= '0;
         r_off         <= '0;
         r_wdata       <= '0;
         r_rd_data     <= '0;
         r_is_rd       <= 1'b0;
         r_last_was_rd <= 1'b0;
         r_oob         <= 1'b0;
         r_rd_valid    <= 1'b0;
         r_wr_ack      <= 1'b0;
      end else begin
         r_rd_valid <= w_resp_nxt && w_is_rd_nxt;
         r_wr_ack   <= w_resp_nxt && !w_is_rd_nxt;
         if (w_acc) begin
            r_addr        <= w_req_addr;
            r_size        <= w_req_size;
            r_off         <= '0;
            r_is_rd       <= w_acc_rd;
            r_last_was_rd <= w_acc_rd;
            r_oob         <= w_req_oob;
            if (w_acc_wr) r_wdata   <= bus.wr_data;
            // Unfetched bytes of a read row must read back as zero.
            if (w_acc_rd) r_rd_data <= '0;
         end else if (r_state == RD_BURST || r_state == WR_BURST) begin
            r_off <= r_off + SIZE_W'(BEAT_BYTES);
            if (r_state == RD_BURST)
               for (int j = 0; j < BEAT_BYTES; j++)
                  if (w_lane_en[j]) r_rd_data[w_lane_idx[j]] <= r_mem[w_lane_addr[j]];
         end
      end
   end

`ifdef XMEM_SRV_BOUNDS_CHECK_EN
   // A new error in the response cycle beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       r_err <= 1'b0;
      else if (w_resp_nxt && w_oob_nxt) r_err <= 1'b1;
      else if (bus.err_clr)             r_err <= 1'b0;
   end
`else
   logic w_unused;
   assign w_unused = bus.err_clr ^ w_oob_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_err <= 1'b0;
      else        r_err <= 1'b0;
   end
`endif

   assign bus.rd_data  = r_rd_data;
   assign bus.rd_valid = r_rd_valid;
   assign bus.wr_ack   = r_wr_ack;
   assign bus.err      = r_err;
endmodule

// File: tb/tb_xmem_row_server.sv
module tb_xmem_row_server;
   typedef logic [31:0][7:0] row_t;
   typedef struct {
      bit         rd;
      int         addr;
      int         size;
      logic [7:0] base;
      logic [7:0] step;
      int         lat;
   } vec_t;

`ifdef XMEM_SRV_BOUNDS_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   xmem_row_if #(.ADDR_W(16), .MAX_XFER_BYTES(32)) bus();

   xmem_row_server #(
      .MEM_BYTES(65536), .ADDR_W(16), .MAX_XFER_BYTES(32), .BEAT_BYTES(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   // reference model: plain byte array + known-byte mask + sticky error
   logic [7:0] m_mem   [65536];
   bit         m_known [65536];
   bit         m_err = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_row(input string nm, input row_t act, input row_t exp, input row_t mask);
      total++;
      if (((act ^ exp) & mask) !== '0) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic int exp_lat(input int size);
      int sz;
      sz = (size > 32) ? 32 : size;
      return (sz + 3) / 4 + 1;
   endfunction

   task automatic model(input bit rd, input int addr, input int size, input row_t wd,
                        input bit clr, output row_t exp, output row_t mask);
      int sz;
      bit oob;
      int a;
      sz   = (size > 32) ? 32 : size;
      oob  = CHK && (addr + sz > 65536);
      exp  = '0;
      mask = '1;
      if (clr) m_err = 1'b0;
      if (oob) m_err = 1'b1;
      for (int i = 0; i < sz; i++) begin
         a = (addr + i) % 65536;
         if (oob) continue;
         if (rd) begin
            exp[i] = m_mem[a];
            if (!m_known[a]) mask[i] = 8'h00;
         end else begin
            m_mem[a]   = wd[i];
            m_known[a] = 1'b1;
         end
      end
   endtask

   // Drive one request from an IDLE cycle, wait (bounded) for its pulse,
   // drop the request in the pulse cycle, then move on to the next cycle.
   task automatic xfer(input bit rd, input logic [15:0] addr, input int size, input row_t wd,
                       input bit clr, output int lat, output row_t rdat, output bit ev);
      lat = 0;
      bus.err_clr = clr;
      if (rd) begin
         bus.rd_req = 1'b1; bus.rd_start_addr = addr; bus.rd_size_bytes = 6'(size);
      end else begin
         bus.wr_req = 1'b1; bus.wr_start_addr = addr; bus.wr_size_bytes = 6'(size);
         bus.wr_data = wd;
      end
      for (int t = 1; t <= 40; t++) begin
         @(posedge clk); #1;
         if ((rd && bus.rd_valid) || (!rd && bus.wr_ack)) begin
            lat = t;
            break;
         end
      end
      rdat = bus.rd_data;
      ev   = bus.err;
      bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.err_clr = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic run_one(input string nm, input bit rd, input int addr, input int size,
                          input row_t wd, input bit clr, input int want_lat);
      int   lat;
      row_t rdat, ex, mk;
      bit   ev;
      xfer(rd, 16'(addr), size, wd, clr, lat, rdat, ev);
      model(rd, addr, size, wd, clr, ex, mk);
      chk({nm, " lat"}, 64'(lat), 64'(want_lat));
      if (rd) chk_row({nm, " data"}, rdat, ex, mk);
      chk({nm, " err"}, 64'(ev), 64'(m_err));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.err_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      m_err = 1'b0;
   endtask

   task automatic arb_round(input string nm);
      int   t_rd, t_wr;
      row_t rdat, wd, ex, mk;
      t_rd = 0; t_wr = 0; rdat = '0;
      for (int i = 0; i < 32; i++) wd[i] = 8'(i * 3 + 1);
      bus.rd_req = 1'b1; bus.rd_start_addr = 16'h0100; bus.rd_size_bytes = 6'd8;
      bus.wr_req = 1'b1; bus.wr_start_addr = 16'h0300; bus.wr_size_bytes = 6'd4;
      bus.wr_data = wd;
      for (int t = 1; t <= 30 && (t_rd == 0 || t_wr == 0); t++) begin
         @(posedge clk); #1;
         if (bus.rd_valid && t_rd == 0) begin t_rd = t; rdat = bus.rd_data; bus.rd_req = 1'b0; end
         if (bus.wr_ack && t_wr == 0)   begin t_wr = t; bus.wr_req = 1'b0; end
      end
      bus.rd_req = 1'b0; bus.wr_req = 1'b0;
      @(posedge clk); #1;
      chk({nm, " rd pulse"}, 64'(t_rd), 64'd3);
      chk({nm, " wr pulse"}, 64'(t_wr), 64'd6);
      model(1'b1, 'h0100, 8, '0, 1'b0, ex, mk);
      chk_row({nm, " rd data"}, rdat, ex, mk);
      model(1'b0, 'h0300, 4, wd, 1'b0, ex, mk);
   endtask

   initial begin
      vec_t tbl [14];
      row_t wd;
      bit   hit;

      bus.rd_req = 1'b0; bus.rd_start_addr = '0; bus.rd_size_bytes = '0;
      bus.wr_req = 1'b0; bus.wr_start_addr = '0; bus.wr_size_bytes = '0;
      bus.wr_data = '0;  bus.err_clr = 1'b0;

      //          rd    addr     size base   step   lat
      tbl[0]  = '{1'b0, 'h0100, 32, 8'h00, 8'h01, 9};
      tbl[1]  = '{1'b1, 'h0100, 32, 8'h00, 8'h00, 9};
      tbl[2]  = '{1'b0, 'h0200, 32, 8'h00, 8'h00, 9};
      tbl[3]  = '{1'b0, 'h0203,  5, 8'hFF, 8'h00, 3};
      tbl[4]  = '{1'b1, 'h0200,  8, 8'h00, 8'h00, 3};
      tbl[5]  = '{1'b1, 'h1234,  0, 8'h00, 8'h00, 1};
      tbl[6]  = '{1'b0, 'h0000,  4, 8'h55, 8'h01, 2};
      tbl[7]  = '{1'b0, 'hFFF8,  8, 8'h00, 8'h00, 3};
      tbl[8]  = '{1'b0, 'hFFFC,  8, 8'hA0, 8'h01, 3};
      tbl[9]  = '{1'b1, 'h0000,  4, 8'h00, 8'h00, 2};
      tbl[10] = '{1'b1, 'hFFF8,  8, 8'h00, 8'h00, 3};
      tbl[11] = '{1'b0, 'h1000, 63, 8'h10, 8'h01, 9};
      tbl[12] = '{1'b1, 'h1000, 40, 8'h00, 8'h00, 9};
      tbl[13] = '{1'b1, 'h0100,  1, 8'h00, 8'h00, 2};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset rd_valid", 64'(bus.rd_valid), 64'd0);
      chk("reset wr_ack",   64'(bus.wr_ack),   64'd0);
      chk("reset err",      64'(bus.err),      64'd0);
      chk("reset rd_data",  64'(bus.rd_data[7:0] | bus.rd_data[31:8] != '0), 64'd0);
      rst_n = 1'b1;

      // arbitration right after reset, then both again
      arb_round("arb1");
      arb_round("arb2");

      // table-driven vectors
      for (int v = 0; v < 14; v++) begin
         for (int i = 0; i < 32; i++) wd[i] = 8'(tbl[v].base + tbl[v].step * i);
         run_one($sformatf("vec%0d", v), tbl[v].rd, tbl[v].addr, tbl[v].size, wd, 1'b0, tbl[v].lat);
      end

      // sticky err cleared by a lone err_clr
      bus.err_clr = 1'b1;
      @(posedge clk); #1;
      bus.err_clr = 1'b0;
      m_err = 1'b0;
      chk("err after clr", 64'(bus.err), 64'(m_err));
      // err_clr held across a new out-of-range request: the error wins
      run_one("err vs clr", 1'b0, 'hFFFC, 8, wd, 1'b1, 3);
      bus.err_clr = 1'b1;
      @(posedge clk); #1;
      bus.err_clr = 1'b0;
      m_err = 1'b0;

      // reset in the 3rd beat of a full-row write
      for (int i = 0; i < 32; i++) wd[i] = 8'h11;
      run_one("rst pre", 1'b0, 'h0400, 32, wd, 1'b0, 9);
      for (int i = 0; i < 32; i++) wd[i] = 8'(8'h80 + i);
      bus.wr_req = 1'b1; bus.wr_start_addr = 16'h0400; bus.wr_size_bytes = 6'd32;
      bus.wr_data = wd;
      hit = 1'b0;
      repeat (3) begin @(posedge clk); #1; if (bus.wr_ack) hit = 1'b1; end
      rst_n = 1'b0;
      #1;
      chk("midrst rd_valid", 64'(bus.rd_valid), 64'd0);
      chk("midrst wr_ack",   64'(bus.wr_ack),   64'd0);
      chk("midrst err",      64'(bus.err),      64'd0);
      chk("midrst rd_data",  64'(bus.rd_data != '0), 64'd0);
      bus.wr_req = 1'b0;
      repeat (2) begin @(posedge clk); #1; if (bus.wr_ack) hit = 1'b1; end
      rst_n = 1'b1;
      m_err = 1'b0;
      chk("midrst no ack", 64'(hit), 64'd0);
      for (int i = 0; i < 8; i++) m_mem['h0400 + i] = 8'(8'h80 + i);
      run_one("midrst read", 1'b1, 'h0400, 32, '0, 1'b0, 9);

      // randomized traffic around the wrap point
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < 8; i++) wd[i*4 +: 4] = $urandom;
         run_one("prefill", 1'b0, (16'hFFC0 + k * 32) % 65536, 32, wd, 1'b0, 9);
      end
      for (int k = 0; k < 200; k++) begin
         bit rd;
         int addr, size;
         rd   = 1'($urandom_range(0, 1));
         addr = (16'hFFC0 + $urandom_range(0, 'h13F)) % 65536;
         size = $urandom_range(0, 40);
         for (int i = 0; i < 8; i++) wd[i*4 +: 4] = $urandom;
         run_one($sformatf("rnd%0d", k), rd, addr, size, wd, 1'b0, exp_lat(size));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
